// File: rtl/sme_pkg.sv
// Shared constants and state encoding for the multi-pattern string-match engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sme_pkg;

    localparam logic [7:0] CHAR_DOT    = 8'h2E;
    localparam logic [7:0] CHAR_CARET  = 8'h5E;
    localparam logic [7:0] CHAR_DOLLAR = 8'h24;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_STR = 3'd1,
        LOAD_PAT = 3'd2,
        SEARCH   = 3'd3,
        DONE     = 3'd4
    } sme_state_t;

endpackage

// File: rtl/sme_pat_cmp.sv
// One pattern slot compared against the string at the current search offset.
// Latency: purely combinational, hit is valid in the same cycle as offset.
// Backpressure: none; evaluated every cycle, the top decides when to use hit.
module sme_pat_cmp
    import sme_pkg::*;
#(
    parameter int STR_LEN = 32,
    parameter int PAT_LEN = 8,
    parameter int IDX_W   = $clog2(STR_LEN),
    parameter int PL_W    = $clog2(PAT_LEN + 1)
) (
    // byte 0 = str[offset-1], byte j+1 = str[offset+j]; out-of-range bytes are 0
    input  logic [(PAT_LEN+1)*8-1:0] win,
    input  logic [PAT_LEN*8-1:0]     pat,
    input  logic [PL_W-1:0]          pat_len,
    input  logic                     loaded,
    input  logic [IDX_W-1:0]         offset,
    input  logic [IDX_W:0]           str_len,
    output logic                     armed,
    output logic                     hit
);

    logic [7:0]       pc [PAT_LEN+1];
    logic [7:0]       wc [PAT_LEN+1];
    logic             caret;
    logic             dollar;
    logic [7:0]       last_c;
    logic [7:0]       follow_c;
    logic [7:0]       p_c;
    logic [PL_W-1:0]  core_len;
    logic [IDX_W+1:0] end_pos;
    logic             core_ok;
    logic             range_ok;
    logic             caret_ok;
    logic             dollar_ok;

    // Strip anchors, then test the core characters, bounds and anchor neighbours.
    always_comb begin
        for (int j = 0; j < PAT_LEN; j++) begin
            pc[j] = pat[j*8 +: 8];
        end
        pc[PAT_LEN] = 8'h00;
        for (int j = 0; j <= PAT_LEN; j++) begin
            wc[j] = win[j*8 +: 8];
        end

        // '^' only anchors in first position, '$' only in last; elsewhere they are literals
        caret  = (pat_len != '0) && (pc[0] == CHAR_CARET);
        last_c = 8'h00;
        for (int j = 0; j < PAT_LEN; j++) begin
            if (PL_W'(j + 1) == pat_len) begin
                last_c = pc[j];
            end
        end
        dollar   = (pat_len > PL_W'(caret)) && (last_c == CHAR_DOLLAR);
        core_len = pat_len - PL_W'(caret) - PL_W'(dollar);
        armed    = loaded && (core_len != '0);

        core_ok  = 1'b1;
        follow_c = 8'h00;
        p_c      = 8'h00;
        for (int j = 0; j < PAT_LEN; j++) begin
            p_c = caret ? pc[j+1] : pc[j];
            if (PL_W'(j) < core_len) begin
                if ((p_c != CHAR_DOT) && (p_c != wc[j+1])) begin
                    core_ok = 1'b0;
                end
            end
            // character just past the core, needed by a trailing '$'
            if (PL_W'(j) == core_len) begin
                follow_c = wc[j+1];
            end
        end

        end_pos   = (IDX_W+2)'(offset) + (IDX_W+2)'(core_len);
        range_ok  = end_pos <= (IDX_W+2)'(str_len);
        caret_ok  = !caret || (offset == '0) || (wc[0] == CHAR_SPACE);
        dollar_ok = !dollar || (end_pos == (IDX_W+2)'(str_len)) || (follow_c == CHAR_SPACE);
        hit       = armed && core_ok && range_ok && caret_ok && dollar_ok;
    end

endmodule

// File: rtl/sme_multi.sv
// Multi-pattern string-match engine: serial string/pattern load, parallel per-slot search.
// Latency: one offset per cycle; valid strobes the cycle after the last offset evaluated.
// Backpressure: none; strobes and start are only honoured in IDLE, ignored otherwise.
module sme_multi
    import sme_pkg::*;
#(
    parameter int STR_LEN = 32,
    parameter int PAT_LEN = 8,
    parameter int NUM_PAT = 4,
    parameter int IDX_W   = $clog2(STR_LEN),
    parameter int SEL_W   = $clog2(NUM_PAT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               chardata,
    input  logic                     isstring,
    input  logic                     ispattern,
    input  logic [SEL_W-1:0]         pat_sel,
    input  logic                     start,
    output logic                     busy,
    output logic                     valid,
    output logic [NUM_PAT-1:0]       match,
    output logic [NUM_PAT*IDX_W-1:0] match_index
);

    localparam int PL_W = $clog2(PAT_LEN + 1);
    localparam int PI_W = $clog2(PAT_LEN);
    localparam logic [IDX_W:0]  STR_MAX = (IDX_W+1)'(STR_LEN);
    localparam logic [PL_W-1:0] PAT_MAX = PL_W'(PAT_LEN);

    sme_state_t               state_q, state_d;
    logic [7:0]               str_q [STR_LEN];
    logic [7:0]               str_d [STR_LEN];
    logic [IDX_W:0]           str_len_q, str_len_d;
    logic [PAT_LEN*8-1:0]     pat_q [NUM_PAT];
    logic [PAT_LEN*8-1:0]     pat_d [NUM_PAT];
    logic [PL_W-1:0]          pat_len_q [NUM_PAT];
    logic [PL_W-1:0]          pat_len_d [NUM_PAT];
    logic [NUM_PAT-1:0]       loaded_q, loaded_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [IDX_W-1:0]         off_q, off_d;
    logic [NUM_PAT-1:0]       found_q, found_d;
    logic [IDX_W-1:0]         fidx_q [NUM_PAT];
    logic [IDX_W-1:0]         fidx_d [NUM_PAT];
    logic [NUM_PAT-1:0]       match_q, match_d;
    logic [NUM_PAT*IDX_W-1:0] midx_q, midx_d;

    logic [(PAT_LEN+1)*8-1:0] win;
    logic [IDX_W+1:0]         wpos;
    logic [NUM_PAT-1:0]       armed;
    logic [NUM_PAT-1:0]       hit;

    // Slice the string around the current offset; one shared window feeds every slot.
    always_comb begin
        win  = '0;
        wpos = '0;
        for (int j = 0; j <= PAT_LEN; j++) begin
            wpos = (IDX_W+2)'(off_q) + (IDX_W+2)'(j);
            if ((wpos >= (IDX_W+2)'(1)) && (wpos <= (IDX_W+2)'(STR_LEN))) begin
                win[j*8 +: 8] = str_q[IDX_W'(wpos - (IDX_W+2)'(1))];
            end
        end
    end

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_cmp
        sme_pat_cmp #(
            .STR_LEN (STR_LEN),
            .PAT_LEN (PAT_LEN),
            .IDX_W   (IDX_W),
            .PL_W    (PL_W)
        ) u_cmp (
            .win     (win),
            .pat     (pat_q[k]),
            .pat_len (pat_len_q[k]),
            .loaded  (loaded_q[k]),
            .offset  (off_q),
            .str_len (str_len_q),
            .armed   (armed[k]),
            .hit     (hit[k])
        );
    end

    // Next-state, load datapath and search bookkeeping.
    always_comb begin
        state_d   = state_q;
        str_d     = str_q;
        str_len_d = str_len_q;
        pat_d     = pat_q;
        pat_len_d = pat_len_q;
        loaded_d  = loaded_q;
        sel_d     = sel_q;
        off_d     = off_q;
        found_d   = found_q;
        fidx_d    = fidx_q;
        match_d   = match_q;
        midx_d    = midx_q;

        case (state_q)
            IDLE: begin
                if (isstring) begin
                    // first character of the burst arrives with the strobe edge
                    str_d[0]  = chardata;
                    str_len_d = (IDX_W+1)'(1);
                    state_d   = LOAD_STR;
                end else if (ispattern) begin
                    sel_d              = pat_sel;
                    pat_d[pat_sel]     = {{((PAT_LEN-1)*8){1'b0}}, chardata};
                    pat_len_d[pat_sel] = PL_W'(1);
                    loaded_d[pat_sel]  = 1'b1;
                    state_d            = LOAD_PAT;
                end else if (start) begin
                    off_d   = '0;
                    found_d = '0;
                    for (int k = 0; k < NUM_PAT; k++) begin
                        fidx_d[k] = '0;
                    end
                    if (str_len_q == '0) begin
                        // nothing to scan: report straight away with no matches
                        match_d = '0;
                        midx_d  = '0;
                        state_d = DONE;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end

            LOAD_STR: begin
                if (!isstring) begin
                    state_d = IDLE;
                end else if (str_len_q < STR_MAX) begin
                    str_d[str_len_q[IDX_W-1:0]] = chardata;
                    str_len_d = str_len_q + 1'b1;
                end
            end

            LOAD_PAT: begin
                if (!ispattern) begin
                    state_d = IDLE;
                end else if (pat_len_q[sel_q] < PAT_MAX) begin
                    pat_d[sel_q][8*pat_len_q[sel_q][PI_W-1:0] +: 8] = chardata;
                    pat_len_d[sel_q] = pat_len_q[sel_q] + 1'b1;
                end
            end

            SEARCH: begin
                for (int k = 0; k < NUM_PAT; k++) begin
                    if (!found_q[k] && hit[k]) begin
                        found_d[k] = 1'b1;
                        fidx_d[k]  = off_q;
                    end
                end
                // stop on the last offset, or once every armed slot has its answer
                if (({1'b0, off_q} + 1'b1 == str_len_q) ||
                    ((|armed) && ((armed & ~found_d) == '0))) begin
                    match_d = found_d;
                    for (int k = 0; k < NUM_PAT; k++) begin
                        midx_d[k*IDX_W +: IDX_W] = fidx_d[k];
                    end
                    state_d = DONE;
                end else begin
                    off_d = off_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and storage registers; reset wipes string, patterns and results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            str_len_q <= '0;
            loaded_q  <= '0;
            sel_q     <= '0;
            off_q     <= '0;
            found_q   <= '0;
            match_q   <= '0;
            midx_q    <= '0;
            for (int i = 0; i < STR_LEN; i++) begin
                str_q[i] <= '0;
            end
            for (int k = 0; k < NUM_PAT; k++) begin
                pat_q[k]     <= '0;
                pat_len_q[k] <= '0;
                fidx_q[k]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            str_q     <= str_d;
            str_len_q <= str_len_d;
            pat_q     <= pat_d;
            pat_len_q <= pat_len_d;
            loaded_q  <= loaded_d;
            sel_q     <= sel_d;
            off_q     <= off_d;
            found_q   <= found_d;
            fidx_q    <= fidx_d;
            match_q   <= match_d;
            midx_q    <= midx_d;
        end
    end

    assign busy        = (state_q == SEARCH);
    assign valid       = (state_q == DONE);
    assign match       = match_q;
    assign match_index = midx_q;

endmodule

// File: doc/sme_multi.md
# sme_multi

Parametrised multi-pattern string-match engine, the next generation of the single-pattern SME. A string and up to NUM_PAT patterns are loaded serially over the same byte interface. A `start` pulse then runs one search pass that evaluates every loaded pattern in parallel and reports a match flag and first-match index per slot. The block sits behind the host character stream in the same place SME does.

## Interface
- STR_LEN, 32: maximum string length in characters.
- PAT_LEN, 8: maximum pattern length per slot, anchors included.
- NUM_PAT, 4: number of pattern slots.
- IDX_W, $clog2(STR_LEN): width of one match index.
- SEL_W, $clog2(NUM_PAT): width of the slot select.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- chardata  in  8  character byte, one per cycle.
- isstring  in  1  string-load strobe; the burst of high cycles is the string.
- ispattern  in  1  pattern-load strobe; the burst of high cycles is one pattern.
- pat_sel  in  SEL_W  target slot; sampled on the first cycle of a pattern burst.
- start  in  1  one-cycle pulse that launches a search.
- busy  out  1  high while searching.
- valid  out  1  one-cycle result strobe.
- match  out  NUM_PAT  per-slot match flag.
- match_index  out  NUM_PAT*IDX_W  per-slot first-match index; slot k occupies bits [k*IDX_W +: IDX_W].

## Operation
- Every output resets to 0. String length, all slot lengths and all slot-loaded bits reset to 0.
- **States:** IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
- **IDLE → LOAD_STR** on isstring:
  - The write pointer restarts at 0, so the old string is overwritten.
  - The length counts characters and saturates at STR_LEN; extra characters are dropped.
  - Return to IDLE when isstring falls.
- **IDLE → LOAD_PAT** on ispattern (isstring has priority if both are high):
  - Latch pat_sel, clear that slot, store characters and set its loaded bit.
  - The slot length saturates at PAT_LEN.
  - Return to IDLE when ispattern falls.
- **IDLE → SEARCH** on start. start, isstring and ispattern are ignored in every state other than IDLE.
- **Special characters:**
  - '.' (0x2E) matches any one character.
  - '^' (0x5E) as the first pattern character: the match offset i must be 0, or str[i-1] must be 0x20. It consumes no string character.
  - '$' (0x24) as the last pattern character: with core length L, i+L must equal the string length, or str[i+L] must be 0x20. It consumes no string character.
  - Anywhere else, '^' and '$' are literal characters.
- **Core match at offset i:** all L core characters match and i+L is no greater than the string length.
- **Search:**
  - One offset per cycle, i = 0, 1, ..., all slots in parallel.
  - A slot records the first, i.e. lowest, matching i and is then frozen.
  - A slot never matches if it is unloaded or its core length is 0.
- **Early exit:** SEARCH ends after offset str_len-1, or as soon as every loaded slot with a nonzero core length has matched, whichever comes first.
- **DONE:** drive match and match_index for one cycle with valid=1, then go to IDLE. Non-matching slots report index 0.
- A reset in any state aborts the operation and clears all stored data.

## Timing
- start is sampled in cycle 0. busy=1 from cycle 1 until DONE. Offset k is evaluated in cycle k+1.
- valid is high in the cycle after the last offset evaluated. For a full pass that is cycle str_len+1.
- str_len=0: valid in cycle 1, all match bits 0.
- match and match_index are registered. They are held (stable) until the next valid.
- Load costs one cycle per character with no bubble. A new burst may start in the cycle after the strobe falls.

## Structure
- Package sme_pkg holds:
  - CHAR_DOT, CHAR_CARET, CHAR_DOLLAR, CHAR_SPACE.
  - The state enum sme_state_t.
- Sub-module sme_pat_cmp, instantiated NUM_PAT times:
  - Inputs: string window, pattern registers, slot length, offset, string length.
  - Output: a combinational hit for the current offset.
- The top level holds the FSM, storage, offset counter and result registers.

## Test plan
- **Basic literal and wildcard:** string "hello world"; slot0 "wor", slot1 "h.llo", slot2 "x.z" → valid at cycle 12, match=3'b011, idx0=6, idx1=0.
- **Anchors:** string "hello world"; slot0 "^wor", slot1 "lo$", slot2 "^ello" → match=3'b011, idx0=6, idx1=3, slot2 no match.
- **Early exit:** string "abcabcabc", only slot0 "abc" loaded → valid at cycle 2, idx0=0. Then check that a pattern reload of slot0 with "cab" gives idx0=2.
- **Overflow:** 40-character string "a...a" followed by 12-character pattern "aaaaaaaaaaab".
  - String saturates at 32 and the pattern at 8 ("aaaaaaaa").
  - Result: match idx 0, full-length search not required.
- **Ignored inputs:** start with nothing loaded → valid at cycle 12 with match=0 for the 11-character string. Then isstring pulsed during SEARCH must not alter the string.
- **Reset mid-search:** drop reset at cycle 5 of a search. busy, valid and match must go to 0 immediately. A following start with no reload must report all slots unloaded (match=0).
